// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between datapath clients and the shared ALU arbiter
interface alu_share_arbiter_if #(parameter int NREQ = 2, parameter int ID_W = 1);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*4-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_answer;
    logic              rsp_carry;
    logic [ID_W-1:0]   rsp_id;
    logic              busy;
    modport slave (input req_valid, req_a, req_b, req_sel, rsp_ready,
                   output req_ready, rsp_valid, rsp_answer, rsp_carry, rsp_id, busy);
    modport master (output req_valid, req_a, req_b, req_sel, rsp_ready,
                    input req_ready, rsp_valid, rsp_answer, rsp_carry, rsp_id, busy);
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one alu_8bit between NREQ requesters,
// with registered operands, registered result and a single response channel.
module alu_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] answer,
    output logic       carryout
);
    logic [8:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};
    // carryout always reflects a+b, independent of sel
    assign carryout = sum[8];
    always_comb begin
        case (sel)
            4'h0: answer = sum[7:0];
            4'h1: answer = a - b;
            4'h2: answer = a * b;
            4'h3: answer = b == 8'd0 ? 8'hff : a / b;
            4'h4: answer = a << 1;
            4'h5: answer = a >> 1;
            4'h6: answer = {a[6:0], a[7]};
            4'h7: answer = {a[0], a[7:1]};
            4'h8: answer = a & b;
            4'h9: answer = a | b;
            4'ha: answer = a ^ b;
            4'hb: answer = ~(a | b);
            4'hc: answer = ~(a & b);
            4'hd: answer = ~(a ^ b);
            4'he: answer = {7'd0, a > b};
            4'hf: answer = {7'd0, a == b};
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input logic clk,
    input logic rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t          state, state_n;
    logic [ID_W-1:0] rr_ptr, gnt, gk, gnt_id;
    logic [7:0]      op_a, op_b, answer;
    logic [3:0]      op_sel;
    logic            carry, any_req;
    assign any_req = |bus.req_valid;
    // scan downward so the candidate closest to rr_ptr is written last and wins
    always_comb begin
        gk = '0;
        gnt = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            gk = ID_W'((int'(rr_ptr) + j) % NREQ);
            if (bus.req_valid[gk]) gnt = gk;
        end
    end
    always_comb begin
        state_n = state == IDLE ? (any_req ? EXEC : IDLE) :
                  state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
        bus.req_ready = (state == IDLE && any_req && !rst) ? NREQ'(1) << gnt : '0;
    end
    assign bus.rsp_valid = state == RESP;
    assign bus.busy = state != IDLE;
    alu_8bit u_alu (.a(op_a), .b(op_b), .sel(op_sel), .answer(answer), .carryout(carry));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            op_a <= '0;
            op_b <= '0;
            op_sel <= '0;
            bus.rsp_answer <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_id <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                op_a <= bus.req_a[{gnt, 3'b000} +: 8];
                op_b <= bus.req_b[{gnt, 3'b000} +: 8];
                op_sel <= bus.req_sel[{gnt, 2'b00} +: 4];
                gnt_id <= gnt;
            end
            if (state == EXEC) begin
                bus.rsp_answer <= answer;
                bus.rsp_carry <= carry;
                bus.rsp_id <= gnt_id;
            end
            if (state == RESP && bus.rsp_ready)
                rr_ptr <= gnt_id == ID_W'(NREQ - 1) ? '0 : gnt_id + 1'b1;
        end
    end
endmodule
